// File: rtl/cpu_fetch_sequencer.sv
// Fetch/sequence unit: fetches 16-bit instructions over a req/ack port, presents
// IR/State to the decoder and applies its PS/IR_L/NS decisions on execute edges.
module cpu_fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PS,
  input  logic        IR_L,
  input  logic        NS,
  input  logic [15:0] BusA,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] IR,
  output logic        State,
  output logic [15:0] PC,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EX0   = 2'd2,
    S_EX1   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_req;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_retired;

  logic        w_accept;
  logic        w_exec;
  logic        w_done;
  logic        w_req_next;
  logic        w_state_out;
  logic [15:0] w_offset;
  logic [15:0] w_pc_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; FETCH waits for the request flag so the reset cycle never fetches
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (r_req) begin
          w_state_next = imem_ack ? S_EX0 : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_state_next = S_EX0;
        end
      end
      S_EX0: begin
        if (NS) begin
          w_state_next = S_EX1;
        end else if (IR_L) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_EX0;
        end
      end
      S_EX1: begin
        w_state_next = IR_L ? S_FETCH : S_EX0;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_accept    = 1'b0;
    w_exec      = 1'b0;
    w_done      = 1'b0;
    w_state_out = 1'b0;
    w_req_next  = (w_state_next == S_FETCH) || (w_state_next == S_WAIT);
    case (r_state)
      S_FETCH: w_accept = r_req && imem_ack;
      S_WAIT:  w_accept = imem_ack;
      S_EX0: begin
        w_exec = 1'b1;
        w_done = !NS;
      end
      S_EX1: begin
        w_exec      = 1'b1;
        w_done      = 1'b1;
        w_state_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_offset = {{8{r_ir[7]}}, r_ir[7:0]};

  always_comb begin
    w_pc_next = r_pc;
    case (PS)
      2'b00: w_pc_next = r_pc;
      2'b01: w_pc_next = r_pc + 16'd1;
      2'b10: w_pc_next = r_pc + w_offset;
      2'b11: w_pc_next = BusA;
      default: w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req     <= 1'b0;
      r_pc      <= RESET_PC;
      r_ir      <= 16'h0000;
      r_retired <= 16'h0000;
    end else begin
      r_req <= w_req_next;
      if (w_accept) begin
        r_ir <= imem_rdata;
      end
      if (w_exec) begin
        r_pc <= w_pc_next;
      end
      if (w_done) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  // PC is frozen while fetching, so it doubles as the registered fetch address
  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign IR        = r_ir;
  assign State     = w_state_out;
  assign PC        = r_pc;
  assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Self-checking bench for cpu_fetch_sequencer: fetched words go into a scoreboard
// queue on ack and are popped when the decoder-facing IR is checked.
module tb_cpu_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PS;
  logic        IR_L;
  logic        NS;
  logic [15:0] BusA;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] IR;
  logic        State;
  logic [15:0] PC;
  logic [15:0] retired;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_ir_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_ret;
  logic [15:0] m_ir;
  logic [15:0] exp_ir;

  always #5 clk = ~clk;

  cpu_fetch_sequencer #(.RESET_PC(16'h0010)) dut (
    .clk        (clk),
    .rst        (rst),
    .PS         (PS),
    .IR_L       (IR_L),
    .NS         (NS),
    .BusA       (BusA),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .IR         (IR),
    .State      (State),
    .PC         (PC),
    .retired    (retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic [1:0] ps, input logic ns, input logic irl, input logic [15:0] busa);
    PS   = ps;
    NS   = ns;
    IR_L = irl;
    BusA = busa;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    n_vec++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL wait_req: imem_req=%b required 1 within 16 cycles", imem_req);
    end
  endtask

  task automatic fetch(input logic [15:0] data);
    wait_req();
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_ir_q.push_back(data);
    m_ir = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    set_ctl(2'b00, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    m_pc = 16'h0010; m_ret = 16'h0000; m_ir = 16'h0000;
    n_vec++; if (PC !== 16'h0010) begin n_err++; $display("FAIL reset_pc: got %h want %h", PC, 16'h0010); end
    n_vec++; if (IR !== 16'h0000) begin n_err++; $display("FAIL reset_ir: got %h want %h", IR, 16'h0000); end
    n_vec++; if (State !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b want 0", State); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_vec++; if (retired !== 16'h0000) begin n_err++; $display("FAIL reset_retired: got %h want 0000", retired); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    wait_req();
    n_vec++; if (imem_addr !== 16'h0010) begin n_err++; $display("FAIL fetch_addr: got %h want %h", imem_addr, 16'h0010); end
    fetch(16'h1234);
    exp_ir = exp_ir_q.pop_front();
    n_vec++; if (IR !== exp_ir) begin n_err++; $display("FAIL fetch_ir: got %h want %h", IR, exp_ir); end
    n_vec++; if (State !== 1'b0) begin n_err++; $display("FAIL fetch_state: got %b want 0", State); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL fetch_req_ex0: got %b want 0", imem_req); end
    set_ctl(2'b01, 1'b0, 1'b1, 16'h0000);
    tick();
    m_pc = 16'h0011; m_ret = 16'h0001;
    n_vec++; if (PC !== m_pc) begin n_err++; $display("FAIL fetch_pc: got %h want %h", PC, m_pc); end
    n_vec++; if (retired !== m_ret) begin n_err++; $display("FAIL fetch_retired: got %h want %h", retired, m_ret); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin n_err++; $display("FAIL fetch_next_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, m_pc); end
  endtask

  task automatic test_wait_states();
    for (int c = 0; c < 3; c++) begin
      imem_ack = 1'b0;
      imem_rdata = 16'hFFFF;
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || PC !== m_pc || IR !== m_ir) begin
        n_err++;
        $display("FAIL wait_cycle%0d: req=%b addr=%h pc=%h ir=%h want 1 %h %h %h", c, imem_req, imem_addr, PC, IR, m_pc, m_pc, m_ir);
      end
      tick();
    end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin n_err++; $display("FAIL wait_cycle3: req=%b addr=%h want 1 %h", imem_req, imem_addr, m_pc); end
    n_vec++; if (IR !== m_ir) begin n_err++; $display("FAIL wait_ir_hold: got %h want %h", IR, m_ir); end
    imem_ack = 1'b1;
    imem_rdata = 16'hA55A;
    exp_ir_q.push_back(16'hA55A);
    m_ir = 16'hA55A;
    tick();
    imem_ack = 1'b0;
    exp_ir = exp_ir_q.pop_front();
    n_vec++; if (IR !== exp_ir) begin n_err++; $display("FAIL wait_ir: got %h want %h", IR, exp_ir); end
    n_vec++; if (imem_req !== 1'b0 || PC !== m_pc) begin n_err++; $display("FAIL wait_done: req=%b pc=%h want 0 %h", imem_req, PC, m_pc); end
    set_ctl(2'b01, 1'b0, 1'b1, 16'h0000);
    tick();
    m_pc = 16'h0012; m_ret = 16'h0002;
    n_vec++; if (PC !== m_pc || retired !== m_ret) begin n_err++; $display("FAIL wait_exec: pc=%h ret=%h want %h %h", PC, retired, m_pc, m_ret); end
  endtask

  task automatic test_two_phase();
    fetch(16'h4321);
    exp_ir = exp_ir_q.pop_front();
    n_vec++; if (IR !== exp_ir) begin n_err++; $display("FAIL tp_ir: got %h want %h", IR, exp_ir); end
    n_vec++; if (State !== 1'b0) begin n_err++; $display("FAIL tp_state0: got %b want 0", State); end
    set_ctl(2'b01, 1'b1, 1'b1, 16'h0BAD);
    tick();
    m_pc = 16'h0013;
    n_vec++; if (State !== 1'b1) begin n_err++; $display("FAIL tp_state1: got %b want 1", State); end
    n_vec++; if (PC !== m_pc) begin n_err++; $display("FAIL tp_pc_ex0: got %h want %h", PC, m_pc); end
    n_vec++; if (retired !== m_ret || imem_req !== 1'b0) begin n_err++; $display("FAIL tp_mid: ret=%h req=%b want %h 0", retired, imem_req, m_ret); end
    set_ctl(2'b11, 1'b1, 1'b1, 16'h0200);
    tick();
    m_pc = 16'h0200; m_ret = m_ret + 16'd1;
    n_vec++; if (State !== 1'b0) begin n_err++; $display("FAIL tp_state_end: got %b want 0", State); end
    n_vec++; if (PC !== m_pc || retired !== m_ret) begin n_err++; $display("FAIL tp_ex1: pc=%h ret=%h want %h %h", PC, retired, m_pc, m_ret); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin n_err++; $display("FAIL tp_next_req: req=%b addr=%h want 1 0200", imem_req, imem_addr); end
  endtask

  task automatic test_rel_branch();
    fetch(16'h0000);
    exp_ir = exp_ir_q.pop_front();
    n_vec++; if (IR !== exp_ir) begin n_err++; $display("FAIL br_ir0: got %h want %h", IR, exp_ir); end
    set_ctl(2'b11, 1'b0, 1'b1, 16'h0005);
    tick();
    m_ret = m_ret + 16'd1;
    n_vec++; if (PC !== 16'h0005) begin n_err++; $display("FAIL br_jump: got %h want 0005", PC); end
    fetch(16'h12FC);
    exp_ir = exp_ir_q.pop_front();
    n_vec++; if (IR !== exp_ir) begin n_err++; $display("FAIL br_ir1: got %h want %h", IR, exp_ir); end
    set_ctl(2'b10, 1'b0, 1'b1, 16'h0000);
    tick();
    m_ret = m_ret + 16'd1;
    n_vec++; if (PC !== 16'h0001 || retired !== m_ret) begin n_err++; $display("FAIL br_back: pc=%h ret=%h want 0001 %h", PC, retired, m_ret); end
    fetch(16'h3407);
    exp_ir = exp_ir_q.pop_front();
    n_vec++; if (IR !== exp_ir) begin n_err++; $display("FAIL br_ir2: got %h want %h", IR, exp_ir); end
    set_ctl(2'b10, 1'b0, 1'b1, 16'h0000);
    tick();
    m_ret = m_ret + 16'd1;
    n_vec++; if (PC !== 16'h0008) begin n_err++; $display("FAIL br_fwd: got %h want 0008", PC); end
    fetch(16'h9999);
    void'(exp_ir_q.pop_front());
    set_ctl(2'b11, 1'b0, 1'b1, 16'hFFFF);
    tick();
    m_ret = m_ret + 16'd1;
    n_vec++; if (imem_addr !== 16'hFFFF) begin n_err++; $display("FAIL br_addr_ffff: got %h want ffff", imem_addr); end
    fetch(16'h5555);
    void'(exp_ir_q.pop_front());
    set_ctl(2'b01, 1'b0, 1'b1, 16'h0000);
    tick();
    m_ret = m_ret + 16'd1;
    m_pc = 16'h0000;
    n_vec++; if (PC !== 16'h0000 || retired !== m_ret) begin n_err++; $display("FAIL br_wrap: pc=%h ret=%h want 0000 %h", PC, retired, m_ret); end
  endtask

  task automatic test_hold();
    fetch(16'hBEEF);
    exp_ir = exp_ir_q.pop_front();
    n_vec++; if (IR !== exp_ir) begin n_err++; $display("FAIL hold_ir: got %h want %h", IR, exp_ir); end
    for (int k = 0; k < 3; k++) begin
      set_ctl(2'b00, 1'b0, 1'b0, 16'h1357);
      imem_ack = 1'b1;
      imem_rdata = 16'h0F0F;
      tick();
      m_ret = m_ret + 16'd1;
      n_vec++;
      if (imem_req !== 1'b0 || IR !== 16'hBEEF || PC !== m_pc || retired !== m_ret || State !== 1'b0) begin
        n_err++;
        $display("FAIL hold_edge%0d: req=%b ir=%h pc=%h ret=%h st=%b want 0 beef %h %h 0", k, imem_req, IR, PC, retired, State, m_pc, m_ret);
      end
    end
    imem_ack = 1'b0;
    set_ctl(2'b01, 1'b1, 1'b0, 16'h0000);
    tick();
    m_pc = m_pc + 16'd1;
    n_vec++; if (State !== 1'b1 || retired !== m_ret) begin n_err++; $display("FAIL hold_ex1: st=%b ret=%h want 1 %h", State, retired, m_ret); end
    set_ctl(2'b01, 1'b0, 1'b0, 16'h0000);
    tick();
    m_pc = m_pc + 16'd1;
    m_ret = m_ret + 16'd1;
    n_vec++;
    if (State !== 1'b0 || imem_req !== 1'b0 || IR !== 16'hBEEF || PC !== m_pc || retired !== m_ret) begin
      n_err++;
      $display("FAIL hold_reexec: st=%b req=%b ir=%h pc=%h ret=%h want 0 0 beef %h %h", State, imem_req, IR, PC, retired, m_pc, m_ret);
    end
    set_ctl(2'b00, 1'b0, 1'b1, 16'h0000);
    tick();
    m_ret = m_ret + 16'd1;
    n_vec++; if (imem_req !== 1'b1 || retired !== m_ret) begin n_err++; $display("FAIL hold_exit: req=%b ret=%h want 1 %h", imem_req, retired, m_ret); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [15:0] d;
      int waits;
      d = 16'($urandom);
      waits = $urandom_range(0, 2);
      wait_req();
      n_vec++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL b2b_addr%0d: got %h want %h", i, imem_addr, m_pc); end
      imem_ack = 1'b0;
      repeat (waits) tick();
      imem_ack = 1'b1;
      imem_rdata = d;
      exp_ir_q.push_back(d);
      tick();
      imem_ack = 1'b0;
      exp_ir = exp_ir_q.pop_front();
      n_vec++; if (IR !== exp_ir) begin n_err++; $display("FAIL b2b_ir%0d: got %h want %h", i, IR, exp_ir); end
      set_ctl(2'b01, 1'b0, 1'b1, 16'h0000);
      tick();
      m_pc = m_pc + 16'd1;
      m_ret = m_ret + 16'd1;
      n_vec++; if (PC !== m_pc || retired !== m_ret) begin n_err++; $display("FAIL b2b_exec%0d: pc=%h ret=%h want %h %h", i, PC, retired, m_pc, m_ret); end
    end
  endtask

  task automatic test_reset_mid();
    fetch(16'h1111);
    void'(exp_ir_q.pop_front());
    set_ctl(2'b01, 1'b1, 1'b1, 16'h0000);
    tick();
    n_vec++; if (State !== 1'b1) begin n_err++; $display("FAIL rm_in_ex1: got %b want 1", State); end
    rst = 1'b1;
    set_ctl(2'b11, 1'b0, 1'b1, 16'h7777);
    tick();
    m_pc = 16'h0010; m_ret = 16'h0000;
    n_vec++;
    if (PC !== 16'h0010 || IR !== 16'h0000 || State !== 1'b0 || imem_req !== 1'b0 || retired !== 16'h0000) begin
      n_err++;
      $display("FAIL rm_ex1: pc=%h ir=%h st=%b req=%b ret=%h want 0010 0000 0 0 0000", PC, IR, State, imem_req, retired);
    end
    rst = 1'b0;
    set_ctl(2'b00, 1'b0, 1'b0, 16'h0000);
    wait_req();
    imem_ack = 1'b0;
    tick();
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rm_in_wait: req=%b want 1", imem_req); end
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    imem_ack = 1'b0;
    n_vec++;
    if (PC !== 16'h0010 || IR !== 16'h0000 || State !== 1'b0 || imem_req !== 1'b0 || retired !== 16'h0000) begin
      n_err++;
      $display("FAIL rm_wait: pc=%h ir=%h st=%b req=%b ret=%h want 0010 0000 0 0 0000", PC, IR, State, imem_req, retired);
    end
    rst = 1'b0;
    fetch(16'h2222);
    exp_ir = exp_ir_q.pop_front();
    n_vec++; if (IR !== exp_ir) begin n_err++; $display("FAIL rm_recover_ir: got %h want %h", IR, exp_ir); end
    set_ctl(2'b01, 1'b0, 1'b1, 16'h0000);
    tick();
    n_vec++; if (PC !== 16'h0011 || retired !== 16'h0001) begin n_err++; $display("FAIL rm_recover: pc=%h ret=%h want 0011 0001", PC, retired); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_wait_states();
    test_two_phase();
    test_rel_branch();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
